multi_latch_bank: RTL and testbench
===================================

# multi_latch_bank

Parametrised bank of edge-triggered holding registers that load from a shared input bus and drive several OR-combined output buses. It generalises the single/dual latch used around the PDP-8 datapath to NREG registers and NBUS output buses, and adds per-register clear and increment strobes with wrap detection. It sits between the major-register bus and the ALU/memory-address paths, wherever a value is captured once per strobe and fanned out to several consumers.

## Interface
Parameters:
- WIDTH, 12, data width of input, registers and each output bus
- NREG, 4, number of holding registers (>=1)
- NBUS, 2, number of output buses (>=1)

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserting clears all state immediately
- in  input  WIDTH  shared load data
- latch  input  NREG  load strobe per register, rising-edge detected
- clr  input  NREG  clear strobe per register, rising-edge detected
- inc  input  NREG  increment strobe per register, rising-edge detected
- oe  input  NBUS*NREG  bit b*NREG+r enables register r onto bus b
- out  output  NBUS*WIDTH  bus b at bits [b*WIDTH +: WIDTH]
- wrap  output  NREG  one-cycle pulse: register r wrapped on increment

## Operation
- Each register r holds data[r] (WIDTH bits).
- Per strobe, one history flop per bit (last_latch, last_clr, last_inc); edge[r] = strobe[r] & ~last[r] sampled at the same rising clk edge. History flops update every clock.
- Per register, per clock, at most one action, priority: clr edge > latch edge > inc edge.
  - clr edge: data[r] <= 0.
  - latch edge: data[r] <= in.
  - inc edge: data[r] <= data[r] + 1 modulo 2^WIDTH; if data[r] was all-ones, wrap[r] <= 1 for that cycle.
  - No edge: data[r] holds.
- Lower-priority edges coinciding with a higher-priority edge are discarded, not deferred (their history flop still updates).
- Registers are independent; simultaneous latch edges on several registers all capture the same in.
- Output bus b = bitwise OR over r of (oe[b*NREG+r] ? data[r] : 0). No enables set -> bus is 0. Multiple enables -> OR of selected registers (intentional, wire-OR bus semantics).
- out is combinational from data[] and oe only; in does not pass through combinationally.

## Timing
- reset low (async): data[*] = 0, wrap = 0, out = 0 for any oe, all history flops = 1. History reset to 1 so a strobe held high across reset release does NOT fire; it must go low for at least one clock and rise again.
- Reset release synchronous to clk is the integrator's responsibility; no internal synchroniser.
- Load latency: strobe first sampled high at edge n (sampled low at edge n-1) -> data[r] updated at edge n, visible on out immediately after edge n (combinational through oe).
- Strobe held high for k cycles -> exactly one action, at the first edge.
- Minimum strobe period: low one clock, high one clock; faster toggling is undefined at the strobe source, not here.
- wrap[r]: registered, high for exactly the cycle following the wrapping edge; cleared on the next edge regardless of strobes.
- Reset mid-operation: state cleared within the same cycle, no partially applied action survives; the first action after release requires a fresh rising strobe.

## Test plan
- Reset/hold: drive latch[0]=1 through reset release with in=12'o1234, oe[0]=1 -> out bus 0 stays 0; drop latch[0] one cycle, raise -> bus 0 = 12'o1234 after that edge.
- Priority: data[1]=12'o0777, same edge latch[1] and clr[1] rise, in=12'o5555 -> data[1]=0; next pair latch[1] and inc[1] rise, in=12'o0042 -> data[1]=12'o0042 (not 12'o0043).
- Wrap: latch 12'o7777 into reg 2, then inc[2] rise -> data[2]=0, wrap[2]=1 for one cycle, wrap[2]=0 next cycle; a second inc -> data[2]=1, wrap[2]=0.
- Bus OR: reg0=12'o0070, reg1=12'o0007, enable both on bus 1, reg0 only on bus 0 -> bus1=12'o0077, bus0=12'o0070; all oe=0 -> both buses 0.
- Held strobe and async reset: hold inc[3] high 5 cycles from data 5 -> data[3]=6 only; assert reset between clock edges -> out and wrap go 0 before the next edge.

Source files
------------

// File: rtl/multi_latch_bank_if.sv
// Data/strobe/output bundle for multi_latch_bank: the shared load bus, the
// per-register strobes, the bus enables and the OR-combined output buses.
interface multi_latch_bank_if #(
    parameter int WIDTH = 12,
    parameter int NREG  = 4,
    parameter int NBUS  = 2
);
    logic [WIDTH-1:0]      in;
    logic [NREG-1:0]       latch;
    logic [NREG-1:0]       clr;
    logic [NREG-1:0]       inc;
    logic [NBUS*NREG-1:0]  oe;
    logic [NBUS*WIDTH-1:0] out;
    logic [NREG-1:0]       wrap;

    modport master (output in, latch, clr, inc, oe, input out, wrap);
    modport slave  (input in, latch, clr, inc, oe, output out, wrap);
endinterface

// File: rtl/multi_latch_bank.sv
// Bank of NREG edge-strobed holding registers (clear > load > increment)
// fanned out onto NBUS wire-OR output buses selected by per-bus enables.
module multi_latch_bank #(
    parameter int WIDTH = 12,
    parameter int NREG  = 4,
    parameter int NBUS  = 2
) (
    input logic               clk,
    input logic               reset,
    multi_latch_bank_if.slave bus
);
    logic [WIDTH-1:0]      data [NREG];
    logic [NREG-1:0]       last_latch, last_clr, last_inc;
    logic [NREG-1:0]       latch_edge, clr_edge, inc_edge;
    logic [NREG-1:0]       wrap_q;
    logic [NBUS*WIDTH-1:0] out_v;

    assign latch_edge = bus.latch & ~last_latch;
    assign clr_edge   = bus.clr   & ~last_clr;
    assign inc_edge   = bus.inc   & ~last_inc;

    // History resets to ones so a strobe held high across reset release stays quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) data[r] <= '0;
            last_latch <= '1;
            last_clr   <= '1;
            last_inc   <= '1;
            wrap_q     <= '0;
        end else begin
            last_latch <= bus.latch;
            last_clr   <= bus.clr;
            last_inc   <= bus.inc;
            for (int r = 0; r < NREG; r++) begin
                wrap_q[r] <= 1'b0;
                if (clr_edge[r]) begin
                    data[r] <= '0;
                end else if (latch_edge[r]) begin
                    data[r] <= bus.in;
                end else if (inc_edge[r]) begin
                    data[r]   <= WIDTH'(data[r] + 1'b1);
                    wrap_q[r] <= &data[r];
                end
            end
        end
    end

    always_comb begin
        out_v = '0;
        for (int b = 0; b < NBUS; b++) begin
            for (int r = 0; r < NREG; r++) begin
                if (bus.oe[b*NREG+r]) out_v[b*WIDTH +: WIDTH] = out_v[b*WIDTH +: WIDTH] | data[r];
            end
        end
    end

    assign bus.out  = out_v;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_multi_latch_bank.sv
// Directed bench for multi_latch_bank: reset hold-off, strobe priority,
// increment wrap, wire-OR buses, held strobes and asynchronous reset.
module tb_multi_latch_bank;
    localparam int WIDTH = 12;
    localparam int NREG  = 4;
    localparam int NBUS  = 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multi_latch_bank_if #(.WIDTH(WIDTH), .NREG(NREG), .NBUS(NBUS)) bus ();

    multi_latch_bank #(.WIDTH(WIDTH), .NREG(NREG), .NBUS(NBUS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe register r alone on bus 0.
    task automatic rd(input int r, input logic [WIDTH-1:0] exp, input string tag);
        bus.oe = '0;
        bus.oe[r] = 1'b1;
        #1;
        chk(tag, 32'(bus.out[WIDTH-1:0]), 32'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset     = 1'b0;
        bus.in    = 12'o1234;
        bus.latch = 4'b0001;
        bus.clr   = '0;
        bus.inc   = '0;
        bus.oe    = '1;
        #12;
        chk("reset_out", bus.out, '0);
        chk("reset_wrap", 32'(bus.wrap), 0);

        // latch[0] held high through reset release must not fire
        @(posedge clk); #1;
        reset = 1'b1;
        tick(); tick();
        rd(0, 12'o0000, "held_through_reset");
        bus.latch = 4'b0000;
        tick();
        bus.latch = 4'b0001;
        tick();
        rd(0, 12'o1234, "fresh_latch_reg0");
        bus.latch = 4'b0000;
        tick();

        // priority: clr over latch, latch over inc
        bus.in = 12'o0777; bus.latch = 4'b0010;
        tick();
        rd(1, 12'o0777, "load_reg1");
        bus.latch = 4'b0000;
        tick();
        bus.in = 12'o5555; bus.latch = 4'b0010; bus.clr = 4'b0010;
        tick();
        rd(1, 12'o0000, "clr_beats_latch");
        bus.latch = 4'b0000; bus.clr = 4'b0000;
        tick();
        bus.in = 12'o0042; bus.latch = 4'b0010; bus.inc = 4'b0010;
        tick();
        rd(1, 12'o0042, "latch_beats_inc");
        chk("no_wrap_on_latch", 32'(bus.wrap), 0);
        bus.latch = 4'b0000; bus.inc = 4'b0000;
        tick();

        // increment wrap on reg 2
        bus.in = 12'o7777; bus.latch = 4'b0100;
        tick();
        bus.latch = 4'b0000;
        tick();
        bus.inc = 4'b0100;
        tick();
        rd(2, 12'o0000, "wrap_value");
        chk("wrap_pulse", 32'(bus.wrap), 32'(4'b0100));
        bus.inc = 4'b0000;
        tick();
        chk("wrap_cleared", 32'(bus.wrap), 0);
        bus.inc = 4'b0100;
        tick();
        rd(2, 12'o0001, "inc_after_wrap");
        chk("no_wrap_second_inc", 32'(bus.wrap), 0);
        bus.inc = 4'b0000;
        tick();

        // wire-OR buses
        bus.in = 12'o0070; bus.latch = 4'b0001;
        tick();
        bus.latch = 4'b0000;
        tick();
        bus.in = 12'o0007; bus.latch = 4'b0010;
        tick();
        bus.latch = 4'b0000;
        tick();
        bus.oe = 8'b0011_0001;
        #1;
        chk("bus1_or", 32'(bus.out[2*WIDTH-1:WIDTH]), 32'(12'o0077));
        chk("bus0_single", 32'(bus.out[WIDTH-1:0]), 32'(12'o0070));
        bus.oe = '0;
        #1;
        chk("no_enables", 32'(bus.out), 0);

        // held inc on reg 3: one action only
        bus.in = 12'o0005; bus.latch = 4'b1000;
        tick();
        bus.latch = 4'b0000;
        tick();
        bus.inc = 4'b1000;
        tick();
        rd(3, 12'o0006, "held_inc_first");
        for (int i = 0; i < 4; i++) tick();
        rd(3, 12'o0006, "held_inc_after5");

        // async reset between edges with a live wrap pulse
        bus.in = 12'o7777; bus.latch = 4'b0100;
        tick();
        bus.latch = 4'b0000;
        tick();
        bus.inc = 4'b1100;
        tick();
        chk("wrap_before_reset", 32'(bus.wrap), 32'(4'b0100));
        bus.oe = '1;
        reset = 1'b0;
        #1;
        chk("async_reset_out", bus.out, '0);
        chk("async_reset_wrap", 32'(bus.wrap), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        rd(3, 12'o0000, "held_inc_after_release");
        bus.inc = 4'b0000;
        tick();
        bus.inc = 4'b1000;
        tick();
        rd(3, 12'o0001, "fresh_inc_after_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
